// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative Hi/Lo multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Define MULDIV_DIV_EN to build the divider; without it divide ops complete as no-ops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);
  localparam int                 CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2     = (2*WIDTH)'(1);

  // S_SKIP pads the no-work paths so they still take two edges to Done
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SKIP, S_WRAP, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi, p_lo, b_r;
  logic             neg_q, wr_res, dz_r;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sgn_a = Op[0] & DataA[WIDTH-1];
  assign sgn_b = Op[0] & DataB[WIDTH-1];
  assign a_mag = sgn_a ? (~DataA + ONE) : DataA;
  assign b_mag = sgn_b ? (~DataB + ONE) : DataB;

  // multiply step: p_lo holds the unconsumed multiplier bits, product shifts in from the top
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;
  assign mul_sum  = {1'b0, p_hi} + {1'b0, b_r & {WIDTH{p_lo[0]}}};
  assign prod     = {p_hi, p_lo};
  assign prod_fix = neg_q ? (~prod + ONE2) : prod;

`ifdef MULDIV_DIV_EN
  logic             is_div, neg_r;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;
  // remainder < divisor, so the low WIDTH bits of the difference are exact when it fits
  assign div_sh   = {p_hi, p_lo[WIDTH-1]};
  assign div_ok   = (div_sh >= {1'b0, b_r});
  assign div_diff = div_sh[WIDTH-1:0] - b_r;
`endif

  logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    res_hi  = prod_fix[2*WIDTH-1:WIDTH];
    res_lo  = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      step_hi = div_ok ? div_diff : div_sh[WIDTH-1:0];
      step_lo = {p_lo[WIDTH-2:0], div_ok};
      res_hi  = neg_r ? (~p_hi + ONE) : p_hi;
      res_lo  = neg_q ? (~p_lo + ONE) : p_lo;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      b_r     <= '0;
      neg_q   <= 1'b0;
      wr_res  <= 1'b0;
      dz_r    <= 1'b0;
      HiOut   <= '0;
      LoOut   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div  <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            p_hi   <= '0;
            p_lo   <= a_mag;
            b_r    <= b_mag;
            neg_q  <= sgn_a ^ sgn_b;
            cnt    <= '0;
            wr_res <= 1'b1;
            dz_r   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= Op[1];
            neg_r  <= sgn_a;
            if (Op[1] && (DataB == '0)) begin
              state  <= S_SKIP;
              wr_res <= 1'b0;
              dz_r   <= 1'b1;
            end else begin
              state <= S_RUN;
              Busy  <= 1'b1;
            end
`else
            if (Op[1]) begin
              state  <= S_SKIP;
              wr_res <= 1'b0;
            end else begin
              state <= S_RUN;
              Busy  <= 1'b1;
            end
`endif
          end else begin
            if (HiWe) HiOut <= WrData;
            if (LoWe) LoOut <= WrData;
          end
        end
        S_RUN: begin
          p_hi <= step_hi;
          p_lo <= step_lo;
          cnt  <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= S_WRAP;
            Busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        S_SKIP: state <= S_WRAP;
        S_WRAP: begin
          if (wr_res) begin
            HiOut <= res_hi;
            LoOut <= res_lo;
          end
          Done    <= 1'b1;
          DivZero <= dz_r;
          state   <= S_DONE;
        end
        S_DONE: begin
          Done    <= 1'b0;
          DivZero <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32); expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         Clk = 1'b0, Rst = 1'b0, Start = 1'b0, HiWe = 1'b0, LoWe = 1'b0;
  logic [1:0]   Op = '0;
  logic [W-1:0] DataA = '0, DataB = '0, WrData = '0;
  logic [W-1:0] HiOut, LoOut;
  logic         Busy, Done, DivZero;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .DataA(DataA), .DataB(DataB),
    .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData), .HiOut(HiOut), .LoOut(LoOut),
    .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           busy;
    int           t;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0, busy_cnt = 0, n_chk = 0, n_err = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model built on native SV arithmetic; tracks Hi/Lo across ops
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e);
    logic signed [2*W-1:0] sa, sbv, p, q, r;
    sa  = {{W{a[W-1]}}, a};
    sbv = {{W{b[W-1]}}, b};
    e.hi = hi_m; e.lo = lo_m; e.dz = 1'b0; e.lat = W + 1; e.busy = W; e.t = 0;
    case (op)
      2'd0:    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      2'd1:    p = sa * sbv;
      default: p = '0;
    endcase
    if (!op[1]) begin
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else begin
`ifdef MULDIV_DIV_EN
      if (b == '0) begin
        e.dz = 1'b1; e.lat = 2; e.busy = 0;
      end else if (!op[0]) begin
        e.lo = a / b;
        e.hi = a % b;
      end else begin
        q = sa / sbv;
        r = sa % sbv;
        e.lo = q[W-1:0];
        e.hi = r[W-1:0];
      end
`else
      e.lat = 2; e.busy = 0;
`endif
    end
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  // called at a negedge with the DUT idle; accept edge is the next posedge
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    model(op, a, b, e);
    Start = 1'b1; Op = op; DataA = a; DataB = b;
    @(negedge Clk);
    Start = 1'b0;
    e.t = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge Clk);
  endtask

  task automatic wr_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    HiWe = 1'b1; WrData = h;
    @(negedge Clk);
    HiWe = 1'b0; LoWe = 1'b1; WrData = l;
    @(negedge Clk);
    LoWe = 1'b0;
    hi_m = h; lo_m = l;
    chk("mthi", 64'(HiOut), 64'(h));
    chk("mtlo", 64'(LoOut), 64'(l));
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst) busy_cnt = 0;
      else begin
        if (Busy) busy_cnt++;
        if (Done) begin
          if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("res_hi", 64'(HiOut), 64'(e.hi));
            chk("res_lo", 64'(LoOut), 64'(e.lo));
            chk("divzero", 64'(DivZero), 64'(e.dz));
            chk("latency", 64'(cyc - e.t), 64'(e.lat));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          end
          busy_cnt = 0;
        end else if (DivZero) chk("divzero_no_done", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] h0, l0;
    logic [1:0]   rop;
    #12;
    chk("rst_hi", 64'(HiOut), 64'd0);
    chk("rst_lo", 64'(LoOut), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dz", 64'(DivZero), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    chk("multu_max_hi", 64'(HiOut), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(LoOut), 64'h0000_0001);

    issue(2'd1, 32'hFFFF_FFFD, 32'h0000_0005); wait_done();
    chk("mult_neg_hi", 64'(HiOut), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(LoOut), 64'hFFFF_FFF1);

    issue(2'd1, 32'h8000_0000, 32'h8000_0000); wait_done();

    issue(2'd3, 32'hFFFF_FFF9, 32'h0000_0002); wait_done();
`ifdef MULDIV_DIV_EN
    chk("div_neg_lo", 64'(LoOut), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(HiOut), 64'hFFFF_FFFF);
`endif
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
`ifdef MULDIV_DIV_EN
    chk("div_ovf_lo", 64'(LoOut), 64'h8000_0000);
    chk("div_ovf_hi", 64'(HiOut), 64'd0);
`endif

    wr_hilo(32'h11, 32'h22);
    issue(2'd2, 32'd5, 32'd0); wait_done();
    chk("div0_hi", 64'(HiOut), 64'h11);
    chk("div0_lo", 64'(LoOut), 64'h22);

    // Start wins over a same-edge Hi write
    HiWe = 1'b1; WrData = 32'h99;
    issue(2'd2, 32'd9, 32'd0);
    HiWe = 1'b0;
    wait_done();
    chk("start_prio_hi", 64'(HiOut), 64'h11);

    // second Start and Lo write during RUN are dropped
    h0 = hi_m; l0 = lo_m;
    issue(2'd0, 32'd3, 32'd4);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 2'd0; DataA = 32'd7; DataB = 32'd9; LoWe = 1'b1; WrData = 32'hAAAA;
    @(negedge Clk);
    Start = 1'b0; LoWe = 1'b0;
    chk("run_hi_stable", 64'(HiOut), 64'(h0));
    chk("run_lo_stable", 64'(LoOut), 64'(l0));
    chk("run_busy", 64'(Busy), 64'd1);
    wait_done();
    chk("ign_lo", 64'(LoOut), 64'd12);
    chk("ign_hi", 64'(HiOut), 64'd0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      issue(rop, $urandom, $urandom);
      wait_done();
    end

    // reset mid-multiply aborts with no Done
    issue(2'd0, 32'h0001_2345, 32'h0000_0777);
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(HiOut), 64'd0);
    chk("abort_lo", 64'(LoOut), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    sb.delete();
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    issue(2'd0, 32'd2, 32'd3); wait_done();
    chk("post_rst_lo", 64'(LoOut), 64'd6);
    chk("post_rst_hi", 64'(HiOut), 64'd0);

    repeat (4) @(negedge Clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
